fetch_controller: RTL and testbench

- Sequences the fetch stage of the 5-stage RV32I pipeline. It drives the stall and redirect controls of the PC register and issues instruction-memory requests over a req/gnt/rvalid handshake.
- It tracks up to MAX_OUTSTANDING in-flight fetches, buffers returned instructions in an in-order queue, and hands them to decode under back-pressure.
- On a redirect from Execute, it discards wrong-path instructions, both queued and still in flight.

---
 rtl/fetch_controller.sv | 189 ++++++++++++++++++
 tb/tb_fetch_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Fetch-stage sequencer for a 5-stage RV32I pipeline. Issues
//               instruction-memory requests over a req/gnt/rvalid handshake,
//               steers the PC register (stall / redirect), tracks in-flight
//               fetches, buffers returned instructions in order and hands
//               them to decode under back-pressure. Wrong-path fetches are
//               discarded after a redirect from Execute.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  // PC register interface
  input  logic [31:0] pcf,
  output logic        stall_f,
  output logic        pc_src_f,
  output logic [31:0] pc_target_f,
  // redirect from Execute
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode interface
  input  logic        stall_d,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d
);

  // Counter width holds 0..MAX_OUTSTANDING; pointer width indexes the queues.
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [PW-1:0] c_last_ptr = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW:0]   c_max      = (CW + 1)'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_outstanding;   // requests granted but not yet answered
  logic [CW-1:0] r_kill;          // in-flight responses still to be discarded

  // PC tags of in-flight requests; occupancy always equals r_outstanding
  logic [31:0]   r_tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;

  // In-order output queue of {pc, instr} waiting for decode
  logic [31:0]   r_q_pc    [MAX_OUTSTANDING];
  logic [31:0]   r_q_instr [MAX_OUTSTANDING];
  logic [PW-1:0] r_q_wr;
  logic [PW-1:0] r_q_rd;
  logic [CW-1:0] r_q_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic w_credit_ok;
  logic w_req;
  logic w_accept;
  logic w_rsp;
  logic w_push;
  logic w_valid;
  logic w_pop;

  // Circular pointer advance for a queue whose depth need not be a power of 2
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == c_last_ptr) ? '0 : ptr + PW'(1);
  endfunction

  // A new request needs a free slot counting both in-flight and buffered
  // entries, so a returning response always finds room in the output queue.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_q_count}) < c_max;
  assign w_req       = !rst && !pc_src_e && w_credit_ok;
  assign w_accept    = w_req && imem_gnt;

  // A response with nothing in flight is a stale one (e.g. from before reset)
  assign w_rsp       = imem_rvalid && (r_outstanding != '0);

  // Responses are kept only when not being killed and not during a redirect
  assign w_push      = w_rsp && (r_kill == '0) && !pc_src_e;

  assign w_valid     = !rst && (r_q_count != '0);
  assign w_pop       = w_valid && !stall_d && !pc_src_e;

  assign imem_req    = w_req;
  assign imem_addr   = pcf;

  // The PC advances once per accepted request and loads the target on redirect
  assign pc_src_f    = !rst && pc_src_e;
  assign pc_target_f = pc_target_e;
  assign stall_f     = rst || !(w_accept || pc_src_e);

  assign valid_d     = w_valid;
  assign instr_d     = w_valid ? r_q_instr[r_q_rd] : NOP_INSTR;
  assign pc_d        = w_valid ? r_q_pc[r_q_rd]    : 32'h0;

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Outstanding count: +1 per accept, -1 per answered response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Kill count: on redirect every request still in flight after this cycle
  // becomes wrong-path; a recomputed value replaces any earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill <= '0;
    end else if (pc_src_e) begin
      r_kill <= r_outstanding - CW'(w_rsp);
    end else if (w_rsp && (r_kill != '0)) begin
      r_kill <= r_kill - CW'(1);
    end
  end

  // Tag FIFO pointers: push on accept, pop on every answered response so
  // tags stay aligned even through killed responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      if (w_accept) begin
        r_tag_wr <= next_ptr(r_tag_wr);
      end
      if (w_rsp) begin
        r_tag_rd <= next_ptr(r_tag_rd);
      end
    end
  end

  // Tag FIFO storage: remember the PC of each accepted request
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_mem[r_tag_wr] <= pcf;
    end
  end

  // Output queue pointers and count; a redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst || pc_src_e) begin
      r_q_wr    <= '0;
      r_q_rd    <= '0;
      r_q_count <= '0;
    end else begin
      if (w_push) begin
        r_q_wr <= next_ptr(r_q_wr);
      end
      if (w_pop) begin
        r_q_rd <= next_ptr(r_q_rd);
      end
      case ({w_push, w_pop})
        2'b10:   r_q_count <= r_q_count + CW'(1);
        2'b01:   r_q_count <= r_q_count - CW'(1);
        default: r_q_count <= r_q_count;
      endcase
    end
  end

  // Output queue storage: capture the returned instruction with its PC tag
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_q_wr]    <= r_tag_mem[r_tag_rd];
      r_q_instr[r_q_wr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Randomized self-checking bench for fetch_controller. Drives a
//               PC register, an in-order instruction memory with random
//               latency, random decode stalls and redirects, and compares the
//               DUT against a queue-based model of the fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  localparam int          MAX_OUTSTANDING = 2;
  localparam logic [31:0] NOP_INSTR       = 32'h00000013;
  localparam int          NUM_CYCLES      = 2000;

  logic        clk;
  logic        rst;
  logic [31:0] pcf;
  logic        stall_f;
  logic        pc_src_f;
  logic [31:0] pc_target_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;

  fetch_controller #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .NOP_INSTR       (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pcf         (pcf),
    .stall_f     (stall_f),
    .pc_src_f    (pc_src_f),
    .pc_target_f (pc_target_f),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_d     (stall_d),
    .valid_d     (valid_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents as a function of address
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: fetches in flight (marked dead once a redirect makes
  // them wrong-path) and the instructions waiting for decode.
  typedef struct { logic [31:0] pc; bit dead; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ready_t;
  typedef struct { logic [31:0] addr; int due; } env_t;

  flight_t     m_fl[$];
  ready_t      m_oq[$];
  env_t        env_q[$];
  logic [31:0] m_next_pc;

  flight_t     it;
  logic [31:0] pcf_nxt;
  bit          e_req, e_acc, e_valid;
  bit          last_redirect;
  bit          stale_hold;

  initial begin
    rst         = 1'b1;
    pcf         = 32'h0;
    pcf_nxt     = 32'h0;
    pc_src_e    = 1'b0;
    pc_target_e = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall_d     = 1'b0;
    m_next_pc   = 32'h0;
    last_redirect = 1'b0;
    stale_hold  = 1'b0;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(negedge clk);
      pcf = pcf_nxt;

      // Stimulus
      rst = (cyc < 3) || (cyc >= 1200 && cyc < 1202);
      if (cyc == 1200) stale_hold = 1'b1;
      stall_d = (cyc >= 400 && cyc < 410) ? 1'b1 : ($urandom_range(0, 3) == 0);
      pc_src_e = !rst && !last_redirect && ($urandom_range(0, 15) == 0);
      last_redirect = pc_src_e;
      pc_target_e = 32'h100 + ($urandom_range(0, 63) << 2);
      imem_gnt = !stale_hold && !(cyc >= 600 && cyc < 603) && ($urandom_range(0, 3) != 0);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (env_q.size() > 0 && env_q[0].due <= cyc && $urandom_range(0, 3) != 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(env_q[0].addr);
      end
      #1;

      if (rst) begin
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_stall_f", 32'(stall_f), 32'h1);
        chk("rst_pc_src_f", 32'(pc_src_f), 32'h0);
        chk("rst_valid_d", 32'(valid_d), 32'h0);
        chk("rst_instr_d", instr_d, NOP_INSTR);
        chk("rst_pc_d", pc_d, 32'h0);
        m_fl.delete();
        m_oq.delete();
        m_next_pc = 32'h0;
      end else begin
        e_req   = !pc_src_e && (m_fl.size() + m_oq.size() < MAX_OUTSTANDING);
        e_acc   = e_req && imem_gnt;
        e_valid = (m_oq.size() > 0);

        chk("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("imem_addr", imem_addr, pcf);
        chk("stall_f", 32'(stall_f), 32'(!(e_acc || pc_src_e)));
        chk("pc_src_f", 32'(pc_src_f), 32'(pc_src_e));
        if (pc_src_e) chk("pc_target_f", pc_target_f, pc_target_e);
        chk("valid_d", 32'(valid_d), 32'(e_valid));
        if (e_valid) begin
          chk("pc_d", pc_d, m_oq[0].pc);
          chk("instr_d", instr_d, m_oq[0].instr);
        end else begin
          chk("idle_instr_d", instr_d, NOP_INSTR);
          chk("idle_pc_d", pc_d, 32'h0);
        end

        // End-to-end: decode sees a contiguous stream from the last target
        if (e_valid && !stall_d && !pc_src_e) begin
          chk("deliv_pc", pc_d, m_next_pc);
          chk("deliv_instr", instr_d, mem_data(pc_d));
          m_next_pc = m_next_pc + 32'h4;
          void'(m_oq.pop_front());
        end

        if (imem_rvalid && m_fl.size() > 0) begin
          it = m_fl.pop_front();
          if (!it.dead && !pc_src_e) m_oq.push_back('{it.pc, imem_rdata});
        end

        if (pc_src_e) begin
          m_oq.delete();
          foreach (m_fl[i]) m_fl[i].dead = 1'b1;
          m_next_pc = pc_target_e;
        end

        if (e_acc) m_fl.push_back('{pcf, 1'b0});
      end

      // Memory: in-order responses, at least one cycle after grant
      if (imem_rvalid) void'(env_q.pop_front());
      if (!rst && imem_req && imem_gnt)
        env_q.push_back('{imem_addr, cyc + 1 + int'($urandom_range(0, 3))});
      if (stale_hold && !rst && env_q.size() == 0) stale_hold = 1'b0;

      // PC register
      if (rst)            pcf_nxt = 32'h0;
      else if (pc_src_f)  pcf_nxt = pc_target_f;
      else if (!stall_f)  pcf_nxt = pcf + 32'h4;
      else                pcf_nxt = pcf;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
